btn_pulse_gen: RTL
==================

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of cycles a synchronized input must be stable to be accepted (10 ms at 100 MHz); legal range >= 1.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, the cycles from the first pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 20000000, the cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port CLK100MHZ, input, 1 bit, the system clock.
REQ-005 The block SHALL have port CPU_RESETN, input, 1 bit, reset; asynchronous, active-high; clock CLK100MHZ.
REQ-006 The block SHALL have port BTNC_RAW, input, 1 bit, the raw asynchronous centre button, active-high.
REQ-007 The block SHALL have port BTND_RAW, input, 1 bit, the raw asynchronous down button, active-high.
REQ-008 The block SHALL have port BTNC, output, 1 bit, a single-cycle "advance" pulse for the operand/operation sequencer.
REQ-009 The block SHALL have port BTND, output, 1 bit, a single-cycle "step back" pulse for the sequencer.
REQ-010 The block SHALL have port btnc_level, output, 1 bit, the debounced held state of the centre button.
REQ-011 The block SHALL have port btnd_level, output, 1 bit, the debounced held state of the down button.

Function
REQ-012 Each raw input SHALL pass through a 2-flip-flop synchronizer; no other logic SHALL sample a raw input.
REQ-013 Each channel SHALL run an independent FSM with the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, each with its own stability counter sized to hold the largest of the three parameters.
REQ-014 When the synchronized input is high, IDLE SHALL go to PRESS_WAIT with the counter cleared.
REQ-015 PRESS_WAIT SHALL go to PRESSED after DEBOUNCE_CYCLES consecutive high samples; any low sample SHALL return it to IDLE with the counter cleared.
REQ-016 When the synchronized input is low, PRESSED SHALL go to RELEASE_WAIT with the counter cleared.
REQ-017 RELEASE_WAIT SHALL go to IDLE after DEBOUNCE_CYCLES consecutive low samples; any high sample SHALL return it to PRESSED with no pulse.
REQ-018 A channel's pulse output SHALL be high for exactly one cycle on the cycle the FSM enters PRESSED from PRESS_WAIT, and SHALL be registered.
REQ-019 Latency from the first clock edge that samples a raw input high to its pulse cycle SHALL be exactly DEBOUNCE_CYCLES+3 cycles for a clean, stable press.
REQ-020 A level output SHALL be high while its FSM is in PRESSED or RELEASE_WAIT, and low otherwise.
REQ-021 Any high excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no level change.
REQ-022 If BTNC and BTND would pulse in the same cycle, both pulses SHALL be suppressed; the level outputs SHALL still update.
REQ-023 BTNC and BTND SHALL never be high in the same cycle.
REQ-024 One press SHALL yield exactly one pulse, regardless of hold length, except as given in REQ-029.

Reset
REQ-025 While CPU_RESETN is high, all FSMs SHALL be in IDLE and all counters and synchronizer flops SHALL be 0.
REQ-026 While CPU_RESETN is high, BTNC, BTND, btnc_level and btnd_level SHALL all be 0.
REQ-027 Reset asserted mid-debounce or mid-press SHALL abort immediately with no pulse.
REQ-028 A button held through the release of reset SHALL be treated as a new press: a pulse DEBOUNCE_CYCLES+3 cycles after the first post-reset edge.

Configuration
REQ-029 With macro BTN_AUTO_REPEAT_EN defined, a channel remaining in PRESSED SHALL emit a further pulse REPEAT_DELAY cycles after its first pulse, then one every REPEAT_PERIOD cycles until it leaves PRESSED; leaving PRESSED SHALL restart the repeat timing.
REQ-030 Repeat pulses SHALL obey REQ-022 and REQ-023.
REQ-031 With BTN_AUTO_REPEAT_EN undefined, no repeat logic SHALL be synthesized, REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and REQ-024 SHALL hold strictly.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, cycle 0 = first edge sampling raw high)
REQ-032 Reset: CPU_RESETN=1 with both raw inputs toggling -> all four outputs 0 throughout; CPU_RESETN=1 pulsed at cycle 5 of a press -> no pulse.
REQ-033 Clean press: BTNC_RAW high for 20 cycles -> BTNC pulse only in cycle 7; btnc_level rises at cycle 7 and falls 4+3 cycles after the raw release.
REQ-034 Glitch and bounce: BTND_RAW high 3 cycles -> no pulse; a press followed by raw low 2 cycles then high again -> only one pulse.
REQ-035 Simultaneous press: both raw inputs rise at cycle 0 -> BTNC=BTND=0 always; both level outputs high from cycle 7.
REQ-036 With BTN_AUTO_REPEAT_EN: BTNC_RAW held cycles 0-27 -> pulses at cycles 7, 17, 22 and 27 only; the same stimulus without the macro -> a pulse at cycle 7 only.

Source files
------------

// File: rtl/btn_pulse_gen.sv
// Debounced button pulse generator: two independent channels (centre/down) with
// one-cycle pulses, level outputs and mutual suppression. Optional auto-repeat: BTN_AUTO_REPEAT_EN.

module btn_debounce_ch #(
  parameter int unsigned CNT_W           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 1,
  parameter int unsigned REPEAT_PERIOD   = 1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt,
  output logic level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             level_q, level_d;
  logic             synced;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  // Low while waiting out the initial delay, high once in the periodic phase.
  logic rpt_phase_q, rpt_phase_d;
`endif

  assign synced = sync_q[1];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    level_d = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
`ifdef BTN_AUTO_REPEAT_EN
    rpt_phase_d = rpt_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (synced) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          evt_d   = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_phase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTO_REPEAT_EN
        // The idle debounce counter doubles as the repeat timer while held.
        else if (cnt_q == (rpt_phase_q ? PER_LAST : DLY_LAST)) begin
          cnt_d       = '0;
          evt_d       = 1'b1;
          rpt_phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_phase_d = 1'b0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      level_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      level_q <= level_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_phase_q <= rpt_phase_d;
`endif
    end
  end

  assign evt   = evt_q;
  assign level = level_q;

endmodule

module btn_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 20000000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic BTNC_RAW,
  input  logic BTND_RAW,
  output logic BTNC,
  output logic BTND,
  output logic btnc_level,
  output logic btnd_level
);

  localparam int unsigned MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > MAX_RPT) ? DEBOUNCE_CYCLES : MAX_RPT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic evt_c, evt_d;
  logic btnc_q, btnc_d;
  logic btnd_q, btnd_d;

  btn_debounce_ch #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_ch_c (
    .clk   (CLK100MHZ),
    .rst   (CPU_RESETN),
    .raw   (BTNC_RAW),
    .evt   (evt_c),
    .level (btnc_level)
  );

  btn_debounce_ch #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_ch_d (
    .clk   (CLK100MHZ),
    .rst   (CPU_RESETN),
    .raw   (BTND_RAW),
    .evt   (evt_d),
    .level (btnd_level)
  );

  // Coincident events are ambiguous to the sequencer, so both are dropped.
  always_comb begin
    btnc_d = evt_c & ~evt_d;
    btnd_d = evt_d & ~evt_c;
  end

  always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
    if (CPU_RESETN) begin
      btnc_q <= 1'b0;
      btnd_q <= 1'b0;
    end else begin
      btnc_q <= btnc_d;
      btnd_q <= btnd_d;
    end
  end

  assign BTNC = btnc_q;
  assign BTND = btnd_q;

endmodule
